uart_tx_frame: RTL
==================

Name: uart_tx_frame

Overview:
Parametrised UART transmitter, the successor to the fixed 8N1 transmitter.
- Frame format is configurable at elaboration: data bits, parity mode and stop bits.
- Upstream logic loads bytes through a valid/ready handshake rather than an edge-detected flag.
- Reports busy and a per-frame done pulse.
- Sits between protocol/command logic and the board TX pin.

Parameters:
- CLK_FRE, 50_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s. BAUD_CNT_MAX = CLK_FRE/BAUD (integer division) clocks per bit; must be >= 2.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- data  in  DATA_BITS  frame payload, LSB transmitted first.
- data_valid  in  1  payload valid.
- data_ready  out  1  block can accept a payload this cycle.
- busy  out  1  frame in progress.
- tx_done  out  1  one-cycle pulse at the end of the last stop bit.
- tx  out  1  serial line, idle high; registered output.

Behaviour:
- Reset values (async, rst_n low): tx=1, data_ready=0, busy=0, tx_done=0, state=IDLE, counters=0. data_ready rises on the first clock edge after rst_n deasserts.
- FSM states: IDLE, START, DATA, PAR, STOP.
- Accept: a rising edge with data_valid && data_ready. At that edge:
  - data is latched into the shift register;
  - state goes to START;
  - tx goes to 0;
  - data_ready goes to 0 and busy goes to 1.
- data_ready is 1 only in IDLE. data is ignored in every other state.
- Baud counter:
  - counts 0..BAUD_CNT_MAX-1 while state != IDLE, and is held at 0 in IDLE;
  - a bit boundary is the cycle where the counter equals BAUD_CNT_MAX-1;
  - every line bit lasts exactly BAUD_CNT_MAX clocks.
- START → DATA at the bit boundary. The tx value for the next bit is registered on that same boundary edge.
- DATA:
  - sends data[0] .. data[DATA_BITS-1];
  - the bit counter increments per boundary;
  - after the last data bit, goes to PAR if PARITY != 0, else STOP.
- PAR sends one bit:
  - odd mode: the XOR of the data bits inverted, so the total count of ones including parity is odd;
  - even mode: the XOR of the data bits.
- STOP: tx=1 for STOP_BITS bit periods. At the final boundary:
  - state goes to IDLE;
  - tx_done=1 for one cycle;
  - busy=0 and data_ready=1 from that edge.
- Back-to-back: if data_valid is held high, the next accept occurs on the clock after returning to IDLE. Consecutive frames are therefore separated by exactly 1 extra idle-high clock.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * BAUD_CNT_MAX clocks, measured from accept to tx_done.
- Reset mid-frame: all state clears immediately and tx returns to 1. No partial frame resumes.

Optional Feature:
Macro UART_TX_FRAME_BREAK_EN.
- When defined:
  - adds input port break_req (1 bit);
  - while in IDLE with break_req=1, tx is driven 0 and data_ready=0;
  - when break_req drops, tx returns to 1 on the next edge and data_ready returns to 1 the edge after;
  - break_req is ignored while busy; an in-flight frame completes normally.
- When not defined: no break_req port; tx in IDLE is always 1.

Test Plan:
- CLK_FRE=1_000_000, BAUD=100_000, 8N1; send 0x55 → tx = 0,1,0,1,0,1,0,1,0,1, each held 10 clocks; tx_done pulses 100 clocks after accept.
- Same clocking, PARITY=2; send 0x07 → parity bit 1. PARITY=1; send 0x07 → parity bit 0. Frame is 110 clocks.
- DATA_BITS=5, STOP_BITS=2; send 0x1F (data upper bits set to junk) → 5 ones, stop high 20 clocks, frame 80 clocks.
- data_valid held high with 0xA5 then 0x3C → two frames, exactly 1 idle clock between the end of the stop bit and the start bit; data_ready low throughout each frame.
- Pulse rst_n low during data bit 3 → tx=1, busy=0 immediately; after release, a new send of 0x81 transmits correctly.
- With UART_TX_FRAME_BREAK_EN defined: break_req=1 for 50 clocks in IDLE → tx low for 50 clocks, data_valid ignored; break_req asserted mid-frame → frame unaffected.

Source files
------------

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: configurable data bits, parity and stop bits, valid/ready load.
// Optional line-break generation in IDLE is enabled by defining UART_TX_FRAME_BREAK_EN.
module uart_tx_frame #(
   parameter int CLK_FRE   = 50_000_000,
   parameter int BAUD      = 9600,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_BITS-1:0] data,
   input  logic                 data_valid,
`ifdef UART_TX_FRAME_BREAK_EN
   input  logic                 break_req,
`endif
   output logic                 data_ready,
   output logic                 busy,
   output logic                 tx_done,
   output logic                 tx
);

   localparam int BAUD_CNT_MAX = CLK_FRE / BAUD;
   localparam int CNT_W        = (BAUD_CNT_MAX > 2) ? $clog2(BAUD_CNT_MAX) : 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_PAR   = 3'd3;
   localparam logic [2:0] S_STOP  = 3'd4;

   logic [2:0]           state_q,    state_d;
   logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
   logic [3:0]           bit_cnt_q,  bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q,    shift_d;
   logic                 par_q,      par_d;
   logic                 tx_q,       tx_d;
   logic                 ready_q,    ready_d;
   logic                 busy_q,     busy_d;
   logic                 done_q,     done_d;
   logic                 baud_end;
   logic                 idle_tx;
   logic                 idle_ready;

`ifdef UART_TX_FRAME_BREAK_EN
   logic brk_q;

   // brk_q delays data_ready by one extra edge after a break ends
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         brk_q <= 1'b0;
      end else begin
         brk_q <= break_req;
      end
   end

   assign idle_tx    = ~break_req;
   assign idle_ready = ~break_req & ~brk_q;
`else
   assign idle_tx    = 1'b1;
   assign idle_ready = 1'b1;
`endif

   assign baud_end = (baud_cnt_q == CNT_W'(BAUD_CNT_MAX - 1));

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      par_d      = par_q;
      tx_d       = tx_q;
      ready_d    = ready_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      baud_cnt_d = '0;
      if (state_q != S_IDLE && !baud_end) begin
         baud_cnt_d = baud_cnt_q + CNT_W'(1);
      end

      case (state_q)
         S_IDLE: begin
            tx_d    = idle_tx;
            ready_d = idle_ready;
            busy_d  = 1'b0;
            if (data_valid && ready_q) begin
               shift_d   = data;
               par_d     = (^data) ^ (PARITY == 1);
               bit_cnt_d = '0;
               state_d   = S_START;
               tx_d      = 1'b0;
               ready_d   = 1'b0;
               busy_d    = 1'b1;
            end
         end
         S_START: begin
            if (baud_end) begin
               state_d = S_DATA;
               tx_d    = shift_q[0];
               shift_d = shift_q >> 1;
            end
         end
         S_DATA: begin
            if (baud_end) begin
               if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                  bit_cnt_d = '0;
                  if (PARITY != 0) begin
                     state_d = S_PAR;
                     tx_d    = par_q;
                  end else begin
                     state_d = S_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  tx_d      = shift_q[0];
                  shift_d   = shift_q >> 1;
               end
            end
         end
         S_PAR: begin
            if (baud_end) begin
               state_d = S_STOP;
               tx_d    = 1'b1;
            end
         end
         S_STOP: begin
            tx_d = 1'b1;
            if (baud_end) begin
               if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
                  state_d   = S_IDLE;
                  bit_cnt_d = '0;
                  done_d    = 1'b1;
                  busy_d    = 1'b0;
                  ready_d   = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            ready_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         baud_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         tx_q       <= 1'b1;
         ready_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         tx_q       <= tx_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign tx         = tx_q;
   assign data_ready = ready_q;
   assign busy       = busy_q;
   assign tx_done    = done_q;

endmodule
